// File: rtl/mem_req_master.sv
// Request-side initiator for the byte-wide memory controller: command FIFO, issue FSM, read return.
// Optional issue statistics (rd_cnt / wr_cnt) are built when MEM_REQ_STATS_EN is defined.
module mem_req_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  busy,
  output logic                  rd_wr,
  output logic                  rd_wr_valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data
`ifdef MEM_REQ_STATS_EN
  ,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
`endif
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned LatW   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;
  localparam int unsigned EntryW = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [EntryW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push, pop, full, empty;
  logic [EntryW-1:0] head;
  logic              head_rd;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

  assign head      = fifo_mem[rd_ptr_q];
  assign head_rd   = head[EntryW-1];
  assign head_addr = head[DATA_WIDTH +: ADDR_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_rd_wr, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic            issue;
  logic            capture;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pop     = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop   = 1'b1;
          issue = 1'b1;
          if (head_rd) begin
            lat_d   = LatW'(RD_LATENCY);
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        lat_d = lat_q - LatW'(1);
        // Counter value 1 marks the edge at which rd_data is valid.
        if (lat_q == LatW'(1)) begin
          capture = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller request and client response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wr_valid <= 1'b0;
      rd_wr       <= 1'b0;
      addr        <= '0;
      wr_data     <= '0;
    end else begin
      rd_wr_valid <= issue;
      if (issue) begin
        rd_wr   <= head_rd;
        addr    <= head_addr;
        wr_data <= head_data;
      end
    end
  end

  // addr still holds the issued read address while waiting, so it doubles as resp_addr source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_addr  <= '0;
    end else begin
      resp_valid <= capture;
      if (capture) begin
        resp_data <= rd_data;
        resp_addr <= addr;
      end
    end
  end

  assign busy = !empty || (state_q == StRdWait);

`ifdef MEM_REQ_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (rd_wr_valid) begin
      if (rd_wr) begin
        if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end else begin
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: directed scenarios plus randomized traffic against
// an in-order transaction model (command queue, reference memory, expected responses).
module tb_mem_req_master;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int Depth = 4;
  localparam int RdLat = 3;

  logic          clk, reset_n;
  logic          cmd_valid, cmd_ready, cmd_rd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] resp_addr;
  logic          busy, rd_wr, rd_wr_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
`ifdef MEM_REQ_STATS_EN
  logic [15:0]   rd_cnt, wr_cnt;
`endif

  mem_req_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(Depth),
    .RD_LATENCY(RdLat)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rd_wr  (cmd_rd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .busy       (busy),
    .rd_wr      (rd_wr),
    .rd_wr_valid(rd_wr_valid),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data)
`ifdef MEM_REQ_STATS_EN
    ,
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    int            due;
  } rsp_t;

  cmd_t          pend_q[$];  // commands accepted but not yet issued
  rsp_t          rsp_q[$];   // reads issued, response outstanding
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] ctrl_mem [16];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            rd_issue = -100;
  logic [AW-1:0] rd_addr_c;
  bit            exp_issue = 0;
  bit            accepted  = 0;
  int            n_rd = 0, n_wr = 0;
  logic [DW-1:0] last_rsp;
  logic          st_valid, st_rd;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_rd_wr_valid", 32'(rd_wr_valid), 0);
    check("rst_rd_wr", 32'(rd_wr), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_data", 32'(resp_data), 0);
    check("rst_resp_addr", 32'(resp_addr), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
  endtask

  // One clock cycle: observe at the falling edge, compare with the model, then drive inputs.
  task automatic cycle();
    cmd_t c;
    rsp_t r;
    @(negedge clk);
    if (rsp_q.size() > 0 && (resp_valid || rsp_q[0].due <= cyc)) begin
      r = rsp_q.pop_front();
      check("resp_valid", 32'(resp_valid), 1);
      check("resp_cycle", 32'(cyc), 32'(r.due));
      check("resp_data", 32'(resp_data), 32'(r.data));
      check("resp_addr", 32'(resp_addr), 32'(r.addr));
      last_rsp = resp_data;
    end else if (resp_valid) begin
      check("resp_spurious", 32'(resp_valid), 0);
    end
    if (rd_wr_valid) begin
      check("strobe_during_read", 32'(rsp_q.size()), 0);
      if (pend_q.size() == 0) begin
        check("strobe_spurious", 32'(rd_wr_valid), 0);
      end else begin
        c = pend_q.pop_front();
        check("issue_rd_wr", 32'(rd_wr), 32'(c.rd));
        check("issue_addr", 32'(addr), 32'(c.addr));
        if (!c.rd) begin
          check("issue_wdata", 32'(wr_data), 32'(c.data));
          ref_mem[c.addr[3:0]] = c.data;
          ctrl_mem[addr[3:0]]  = wr_data;
          n_wr++;
        end else begin
          r.data = ref_mem[c.addr[3:0]];
          r.addr = c.addr;
          r.due  = cyc + RdLat;
          rsp_q.push_back(r);
          rd_issue  = cyc;
          rd_addr_c = addr;
          n_rd++;
        end
      end
    end else if (exp_issue) begin
      check("issue_missing", 32'(rd_wr_valid), 1);
    end
    check("cmd_ready", 32'(cmd_ready), 32'(pend_q.size() < Depth));
    check("busy", 32'(busy), 32'(pend_q.size() != 0 || rsp_q.size() != 0));
    exp_issue = (pend_q.size() != 0) && (rsp_q.size() == 0);
    // Controller model: rd_data valid only in the cycle before the sampling edge.
    rd_data = (cyc == rd_issue + RdLat - 1) ? ctrl_mem[rd_addr_c[3:0]] : DW'($urandom);
    cmd_valid = st_valid;
    cmd_rd_wr = st_rd;
    cmd_addr  = st_addr;
    cmd_wdata = st_data;
    accepted  = st_valid && (pend_q.size() < Depth);
    if (accepted) begin
      c.rd   = st_rd;
      c.addr = st_addr;
      c.data = st_data;
      pend_q.push_back(c);
    end
  endtask

  task automatic idle(input int n);
    st_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int waits);
    st_valid = 1'b1;
    st_rd    = rd;
    st_addr  = a;
    st_data  = d;
    waits    = 0;
    cycle();
    while (!accepted && waits < 100) begin
      waits++;
      cycle();
    end
    if (!accepted) check("send_timeout", 32'(accepted), 1);
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    st_valid = 1'b0;
    while ((pend_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(pend_q.size() + rsp_q.size()), 0);
    idle(2);
  endtask

  initial begin
    int w;
    int stalls;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rd_wr = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rd_data   = '0;
    st_valid  = 1'b0;
    st_rd     = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = '0;
      ctrl_mem[i] = '0;
    end
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single write, then a read of the same address.
    send(1'b0, 16'd20, 8'd2, w);
    idle(4);
    send(1'b1, 16'd20, 8'd0, w);
    idle(RdLat + 3);
    check("read20_data", 32'(last_rsp), 2);

    // Write / read / write back-to-back.
    send(1'b0, 16'd22, 8'd4, w);
    send(1'b1, 16'd22, 8'd0, w);
    send(1'b0, 16'd24, 8'd6, w);
    drain();
    check("read22_data", 32'(last_rsp), 4);

    // Fill the FIFO behind a stalled read; six writes held on cmd_valid.
    stalls = 0;
    send(1'b1, 16'd24, 8'd0, w);
    for (int i = 0; i < 6; i++) begin
      send(1'b0, AW'(30 + i), DW'(10 + i), w);
      stalls += w;
    end
    check("fifo_full_stall", 32'(stalls > 0), 1);
    drain();
    check("read24_data", 32'(last_rsp), 6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (accepted || !st_valid) begin
        st_valid = ($urandom_range(0, 3) != 0);
        st_rd    = $urandom_range(0, 1);
        st_addr  = AW'($urandom_range(0, 15));
        st_data  = DW'($urandom);
      end
      cycle();
    end
    drain();

    // Reset while a read is outstanding with two writes queued.
    send(1'b1, 16'd3, 8'd0, w);
    send(1'b0, 16'd4, 8'd1, w);
    send(1'b0, 16'd5, 8'd2, w);
    cycle();
    check("pre_reset_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    pend_q.delete();
    rsp_q.delete();
    exp_issue = 0;
    rd_issue  = -100;
    cmd_valid = 1'b0;
    n_rd = 0;
    n_wr = 0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset_n = 1'b1;
    idle(10);

    // Issue counts after reset: 3 writes and 2 reads.
    send(1'b0, 16'd40, 8'd7, w);
    send(1'b0, 16'd41, 8'd8, w);
    send(1'b1, 16'd40, 8'd0, w);
    send(1'b0, 16'd42, 8'd9, w);
    send(1'b1, 16'd41, 8'd0, w);
    drain();
    check("read41_data", 32'(last_rsp), 8);
    check("model_wr_count", 32'(n_wr), 3);
`ifdef MEM_REQ_STATS_EN
    check("wr_cnt", 32'(wr_cnt), 32'(n_wr));
    check("rd_cnt", 32'(rd_cnt), 32'(n_rd));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_master.md
# mem_req_master

Request-side initiator for the byte-wide memory controller. It accepts read/write commands from a client through a small command FIFO and issues them one per cycle on the controller's `rd_wr` / `rd_wr_valid` / `addr` / `wr_data` interface. It captures `rd_data` after a fixed read latency and returns it to the client as a one-cycle response pulse. It sits between the client logic and the memory controller, whose ports it drives directly.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: data width.
- `ADDR_WIDTH`, default 16: address width.
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of 2, at least 2.
- `RD_LATENCY`, default 1: cycles from the read-issue edge to the edge at which `rd_data` is sampled; at least 1.

**Ports**
- One clock; reset is asynchronous and active-low.
- `clk` input, 1: clock; all state changes on the rising edge.
- `reset_n` input, 1: asynchronous active-low reset.
- `cmd_valid` input, 1: client command present.
- `cmd_ready` output, 1: FIFO can accept a command.
- `cmd_rd_wr` input, 1: 1 = read, 0 = write.
- `cmd_addr` input, ADDR_WIDTH: command address.
- `cmd_wdata` input, DATA_WIDTH: write data; ignored for reads.
- `resp_valid` output, 1: one-cycle pulse carrying read data.
- `resp_data` output, DATA_WIDTH: read data.
- `resp_addr` output, ADDR_WIDTH: address of the returned read.
- `busy` output, 1: FIFO non-empty or read outstanding.
- `rd_wr` output, 1: controller direction; 1 = read, 0 = write.
- `rd_wr_valid` output, 1: controller request strobe.
- `addr` output, ADDR_WIDTH: controller address.
- `wr_data` output, DATA_WIDTH: controller write data.
- `rd_data` input, DATA_WIDTH: controller read data.

## Operation

**Command FIFO**
- A command is pushed when `cmd_valid && cmd_ready`.
- `cmd_ready = !full`. It is combinational from the count, so a full FIFO refuses a push even if a pop happens in the same cycle.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. The count is log2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop when not full or empty leaves the count unchanged.

**FSM**
- IDLE:
  - If the FIFO is non-empty: pop the head and register `rd_wr`, `addr`, and `wr_data` from it, and set `rd_wr_valid` = 1.
  - On a write, stay in IDLE, so back-to-back writes issue on consecutive cycles.
  - On a read, load the latency counter with RD_LATENCY and go to RD_WAIT.
  - If the FIFO is empty: `rd_wr_valid` = 0.
- RD_WAIT:
  - `rd_wr_valid` = 0 and the counter decrements each edge.
  - At the edge where the counter reaches 1: capture `rd_data` into `resp_data`, capture the issued address into `resp_addr`, set `resp_valid` = 1, and go to IDLE.
- `resp_valid` is high for exactly one cycle per read. There is no response backpressure.
- `addr`, `wr_data`, and `rd_wr` hold their last issued values when `rd_wr_valid` = 0.
- `busy = (count != 0) || (state == RD_WAIT)`.

## Timing

- Reset values (asynchronous): `rd_wr_valid` = 0, `rd_wr` = 0, `addr` = 0, `wr_data` = 0, `resp_valid` = 0, `resp_data` = 0, `resp_addr` = 0, FIFO empty, state IDLE, counter 0. `cmd_ready` = 1 and `busy` = 0 while held in reset.
- **Command to issue:** a command pushed into an empty FIFO at edge E is issued at edge E+1. `rd_wr_valid` is high during cycle E+1 to E+2.
- **Read latency:** a read issued at edge I has `rd_data` sampled at edge I+RD_LATENCY. `resp_valid` is high for the cycle following that edge.
- **Throughput:**
  - Writes: one per cycle.
  - Reads: one per RD_LATENCY+1 cycles.
  - A write queued behind a read issues at the edge after the response edge.
- **Reset mid-operation:** the FIFO is flushed, a pending read is abandoned, and no `resp_valid` is generated. After release the FSM is in IDLE.
- **Full FIFO:** `cmd_ready` = 0. A `cmd_valid` held high is accepted on the first cycle after a pop frees an entry.
- **Empty FIFO in IDLE:** no strobe and no state change.

## Configuration

- `MEM_REQ_STATS_EN`
  - Defined: adds outputs `rd_cnt` and `wr_cnt`, each 16 bits, reset to 0.
    - Each counts issued reads or writes (incrementing on `rd_wr_valid`, by `rd_wr`).
    - Each saturates at 16'hFFFF.
  - Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan

- Reset, then push write (addr 16'd20, data 8'd2) -> next edge `rd_wr_valid` = 1, `rd_wr` = 0, `addr` = 20, `wr_data` = 2 for one cycle. Then `busy` = 0.
- Push read addr 20 with the memory model returning 8'd2, RD_LATENCY = 1 -> `resp_valid` pulses once, 2 cycles after the push edge, with `resp_data` = 2 and `resp_addr` = 20.
- Push write (22, 4), read 22, write (24, 6) back-to-back -> issue order W22, R22, W24. W24 issues the edge after the R22 response. The read returns 4.
- Hold `cmd_valid` for 6 writes while the FSM is stalled by a read with RD_LATENCY = 3 -> `cmd_ready` drops after 4 entries. All 6 writes are eventually issued in order with no loss or duplication.
- Assert `reset_n` = 0 during RD_WAIT with 2 commands queued -> no `resp_valid`, all outputs at their reset values, and no further `rd_wr_valid` after release.
- With `MEM_REQ_STATS_EN`: issue 3 writes and 2 reads -> `wr_cnt` = 3, `rd_cnt` = 2.
